// File: rtl/ext_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ext_pkg                                                         |
// | Brief  : Op codes, state encoding and helpers shared by the extender.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package ext_pkg;

    localparam logic [2:0] EXT_OP_ZERO = 3'd0;
    localparam logic [2:0] EXT_OP_SIGN = 3'd1;
    localparam logic [2:0] EXT_OP_LUI  = 3'd2;
    localparam logic [2:0] EXT_OP_LB   = 3'd3;
    localparam logic [2:0] EXT_OP_LBU  = 3'd4;
    localparam logic [2:0] EXT_OP_LH   = 3'd5;
    localparam logic [2:0] EXT_OP_LHU  = 3'd6;
    localparam logic [2:0] EXT_OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } ext_state_e;

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == EXT_OP_LH) || (op == EXT_OP_LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ext_pipe_if                                                     |
// | Brief  : Request/result valid-ready bundle for the pipelined extender.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface ext_pipe_if #(
    parameter int OUT_W = 32
);
    localparam int OFF_W = $clog2(OUT_W / 8);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [OUT_W-1:0] in_data;
    logic [OFF_W-1:0] in_off;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_data, in_off, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_off, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ext_core                                                        |
// | Brief  : Combinational immediate / load-data extender.                   |
// |          EXT_PIPE_ERR_EN adds the err output (reserved op, odd LH/LHU).  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ext_core
    import ext_pkg::*;
#(
    parameter  int OUT_W = 32,
    parameter  int IN_W  = 16,
    localparam int OFF_W = $clog2(OUT_W / 8)
) (
    input  wire logic [2:0]       op,
    input  wire logic [OUT_W-1:0] data,
    input  wire logic [OFF_W-1:0] off,
    output logic      [OUT_W-1:0] res
`ifdef EXT_PIPE_ERR_EN
    ,
    output logic                  err
`endif
);

    logic [IN_W-1:0]  w_imm;
    logic [OFF_W-1:0] w_hoff;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign w_imm  = data[IN_W-1:0];
    // Halfword select ignores off[0], so misaligned requests read the aligned half.
    assign w_hoff = off & ~OFF_W'(1);
    assign w_byte = 8'(data >> {off, 3'b000});
    assign w_half = 16'(data >> {w_hoff, 3'b000});

    always_comb begin
        res = '0;
        case (op)
            EXT_OP_ZERO: res = {{(OUT_W-IN_W){1'b0}}, w_imm};
            EXT_OP_SIGN: res = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
            EXT_OP_LUI:  res = {w_imm, {(OUT_W-IN_W){1'b0}}};
            EXT_OP_LB:   res = {{(OUT_W-8){w_byte[7]}}, w_byte};
            EXT_OP_LBU:  res = {{(OUT_W-8){1'b0}}, w_byte};
            EXT_OP_LH:   res = {{(OUT_W-16){w_half[15]}}, w_half};
            EXT_OP_LHU:  res = {{(OUT_W-16){1'b0}}, w_half};
            default:     res = '0;
        endcase
    end

`ifdef EXT_PIPE_ERR_EN
    assign err = (op == EXT_OP_RSVD) | (op_is_half(op) & off[0]);
`endif

endmodule
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : ext_pipe                                                        |
// | Brief  : Registered extender with 2-entry skid buffer, valid/ready.      |
// |          EXT_PIPE_ERR_EN carries an error flag alongside each result.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module ext_pipe
    import ext_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int IN_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ext_pipe_if.slave bus
);

    ext_state_e       r_state;
    ext_state_e       w_state_nxt;
    logic [OUT_W-1:0] r_main_data;
    logic [OUT_W-1:0] r_skid_data;
    logic [OUT_W-1:0] w_core_data;
    logic             w_push;
    logic             w_pop;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

`ifdef EXT_PIPE_ERR_EN
    logic             w_core_err;
    logic             r_main_err;
    logic             r_skid_err;
`endif

    ext_core #(
        .OUT_W (OUT_W),
        .IN_W  (IN_W)
    ) u_core (
        .op    (bus.in_op),
        .data  (bus.in_data),
        .off   (bus.in_off),
        .res   (w_core_data)
`ifdef EXT_PIPE_ERR_EN
        ,
        .err   (w_core_err)
`endif
    );

    // in_ready decodes the state register only, keeping out_ready off the input path.
    assign bus.in_ready  = (r_state != ST_FULL);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_main_data;
    assign w_push        = bus.in_valid & bus.in_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_push) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ST_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= w_core_data;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= w_core_data;
            end
        end
    end

`ifdef EXT_PIPE_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_err <= 1'b0;
            r_skid_err <= 1'b0;
        end else begin
            if (w_load_main) begin
                r_main_err <= w_core_err;
            end else if (w_main_from_skid) begin
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_err <= w_core_err;
            end
        end
    end

    assign bus.out_err = r_main_err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule
`default_nettype wire
